alu_rs: RTL and testbench

- Reservation station that feeds the combinational integer/branch ALU. It buffers issued ALU/branch ops until both operands are resolved, snooping the ALU and LSB broadcast buses.
- Each cycle it dispatches at most one ready entry, the lowest index first, over a registered operand bus to the ALU.
- Sits between decoder/issue (upstream) and ALU (downstream); the ALU result returns on alu_cdb_* for wakeup.

---
 rtl/alu_rs_pkg.sv | 49 ++++
 rtl/rs_select.sv | 32 +++
 rtl/alu_rs.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_rs.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// -----------------------------------------------------------------------------
// alu_rs_pkg
//   Shared constants for the ALU reservation station and its neighbours:
//   default sizing, operand/opcode widths and the integer/branch opcode set.
//   Opcode 0 is reserved as NOP and means "nothing dispatched" on the ALU bus.
// -----------------------------------------------------------------------------
package alu_rs_pkg;

    // Default sizing (the top module exposes these as parameters)
    localparam int RS_SIZE_DEF = 8;
    localparam int TAG_W_DEF   = 5;

    // Datapath widths
    localparam int OP_W   = 7;
    localparam int WORD_W = 32;

    // Opcode encoding; every real operation is nonzero
    localparam logic [OP_W-1:0] OP_NOP   = 7'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 7'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 7'd2;
    localparam logic [OP_W-1:0] OP_SLL   = 7'd3;
    localparam logic [OP_W-1:0] OP_SLT   = 7'd4;
    localparam logic [OP_W-1:0] OP_SLTU  = 7'd5;
    localparam logic [OP_W-1:0] OP_XOR   = 7'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 7'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 7'd8;
    localparam logic [OP_W-1:0] OP_OR    = 7'd9;
    localparam logic [OP_W-1:0] OP_AND   = 7'd10;
    localparam logic [OP_W-1:0] OP_ADDI  = 7'd11;
    localparam logic [OP_W-1:0] OP_SLTI  = 7'd12;
    localparam logic [OP_W-1:0] OP_SLTIU = 7'd13;
    localparam logic [OP_W-1:0] OP_XORI  = 7'd14;
    localparam logic [OP_W-1:0] OP_ORI   = 7'd15;
    localparam logic [OP_W-1:0] OP_ANDI  = 7'd16;
    localparam logic [OP_W-1:0] OP_SLLI  = 7'd17;
    localparam logic [OP_W-1:0] OP_SRLI  = 7'd18;
    localparam logic [OP_W-1:0] OP_SRAI  = 7'd19;
    localparam logic [OP_W-1:0] OP_LUI   = 7'd20;
    localparam logic [OP_W-1:0] OP_AUIPC = 7'd21;
    localparam logic [OP_W-1:0] OP_JAL   = 7'd22;
    localparam logic [OP_W-1:0] OP_JALR  = 7'd23;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'd24;
    localparam logic [OP_W-1:0] OP_BNE   = 7'd25;
    localparam logic [OP_W-1:0] OP_BLT   = 7'd26;
    localparam logic [OP_W-1:0] OP_BGE   = 7'd27;
    localparam logic [OP_W-1:0] OP_BLTU  = 7'd28;
    localparam logic [OP_W-1:0] OP_BGEU  = 7'd29;

endpackage

// File: rtl/rs_select.sv
// -----------------------------------------------------------------------------
// rs_select
//   Lowest-index priority encoder. Reports whether any request bit is set and
//   the index of the lowest set bit (0 when none is set).
//
//   Ports:
//     req    in   N            request vector
//     found  out  1            at least one bit of req is set
//     idx    out  clog2(N)     index of the lowest set bit
// -----------------------------------------------------------------------------
module rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs
//   Reservation station in front of the combinational integer/branch ALU.
//   Buffers issued ops until both operands are known, snooping the ALU and
//   load broadcast buses, and dispatches at most one ready entry per cycle
//   (lowest index first) over a registered operand bus.
//
//   Ports:
//     clk_in, rst_in (async, active-low), rdy_in (global stall), flush_in
//     iss_*      issue request from decode: op, operand values/tags, imm, rd, pc
//     full       no free entry (combinational from the busy vector)
//     alu_cdb_*  ALU result broadcast (valid/tag/value)
//     lsb_cdb_*  load result broadcast (valid/tag/value)
//     alu_op/alu_vi/alu_vj/alu_imm/alu_pc/alu_rd  registered dispatch bus;
//                alu_op == 0 means nothing dispatched this cycle
// -----------------------------------------------------------------------------
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,

    input  logic              iss_valid,
    input  logic [OP_W-1:0]   iss_op,
    input  logic [WORD_W-1:0] iss_vi,
    input  logic [WORD_W-1:0] iss_vj,
    input  logic              iss_qi_busy,
    input  logic              iss_qj_busy,
    input  logic [TAG_W-1:0]  iss_qi,
    input  logic [TAG_W-1:0]  iss_qj,
    input  logic [WORD_W-1:0] iss_imm,
    input  logic [TAG_W-1:0]  iss_rd,
    input  logic [WORD_W-1:0] iss_pc,
    output logic              full,

    input  logic              alu_cdb_valid,
    input  logic [TAG_W-1:0]  alu_cdb_tag,
    input  logic [WORD_W-1:0] alu_cdb_val,
    input  logic              lsb_cdb_valid,
    input  logic [TAG_W-1:0]  lsb_cdb_tag,
    input  logic [WORD_W-1:0] lsb_cdb_val,

    output logic [OP_W-1:0]   alu_op,
    output logic [WORD_W-1:0] alu_vi,
    output logic [WORD_W-1:0] alu_vj,
    output logic [WORD_W-1:0] alu_imm,
    output logic [WORD_W-1:0] alu_pc,
    output logic [TAG_W-1:0]  alu_rd
);

    localparam int IDX_W = $clog2(RS_SIZE);

    // Per-entry payload; busy is kept separately because it is the only
    // per-entry field that needs a reset value.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [WORD_W-1:0] vi;
        logic [WORD_W-1:0] vj;
        logic              qi_busy;
        logic              qj_busy;
        logic [TAG_W-1:0]  qi;
        logic [TAG_W-1:0]  qj;
        logic [WORD_W-1:0] imm;
        logic [TAG_W-1:0]  rd;
        logic [WORD_W-1:0] pc;
    } entry_t;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    entry_t             new_ent;

    logic [OP_W-1:0]    alu_op_q,  alu_op_d;
    logic [WORD_W-1:0]  alu_vi_q,  alu_vi_d;
    logic [WORD_W-1:0]  alu_vj_q,  alu_vj_d;
    logic [WORD_W-1:0]  alu_imm_q, alu_imm_d;
    logic [WORD_W-1:0]  alu_pc_q,  alu_pc_d;
    logic [TAG_W-1:0]   alu_rd_q,  alu_rd_d;

    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic               ready_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;

    // True when either broadcast bus carries a result for this tag
    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        return (alu_cdb_valid && (alu_cdb_tag == tag)) ||
               (lsb_cdb_valid && (lsb_cdb_tag == tag));
    endfunction

    // Value for a matching tag; the ALU bus wins if both buses match
    function automatic logic [WORD_W-1:0] cdb_val(input logic [TAG_W-1:0] tag);
        if (alu_cdb_valid && (alu_cdb_tag == tag)) begin
            return alu_cdb_val;
        end
        return lsb_cdb_val;
    endfunction

    // Readiness is judged on registered state only, so anything woken or
    // issued at an edge becomes dispatchable one cycle later.
    always_comb begin
        free_vec  = ~busy_q;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy_q[i] && !ent_q[i].qi_busy && !ent_q[i].qj_busy;
        end
    end

    assign full = &busy_q;

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.N(RS_SIZE)) u_ready_sel (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    // New entry with issue-time forwarding from whichever CDB matches now
    always_comb begin
        new_ent.op      = iss_op;
        new_ent.vi      = iss_vi;
        new_ent.vj      = iss_vj;
        new_ent.qi_busy = iss_qi_busy;
        new_ent.qj_busy = iss_qj_busy;
        new_ent.qi      = iss_qi;
        new_ent.qj      = iss_qj;
        new_ent.imm     = iss_imm;
        new_ent.rd      = iss_rd;
        new_ent.pc      = iss_pc;
        if (iss_qi_busy && cdb_hit(iss_qi)) begin
            new_ent.vi      = cdb_val(iss_qi);
            new_ent.qi_busy = 1'b0;
        end
        if (iss_qj_busy && cdb_hit(iss_qj)) begin
            new_ent.vj      = cdb_val(iss_qj);
            new_ent.qj_busy = 1'b0;
        end
    end

    always_comb begin
        busy_d    = busy_q;
        ent_d     = ent_q;
        alu_op_d  = alu_op_q;
        alu_vi_d  = alu_vi_q;
        alu_vj_d  = alu_vj_q;
        alu_imm_d = alu_imm_q;
        alu_pc_d  = alu_pc_q;
        alu_rd_d  = alu_rd_q;

        // rdy_in low freezes everything, including CDB snooping
        if (rdy_in) begin
            if (flush_in) begin
                busy_d   = '0;
                alu_op_d = OP_NOP;
            end else begin
                // Wakeup: both buses, both operands, all busy entries at once
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        if (ent_q[i].qi_busy && cdb_hit(ent_q[i].qi)) begin
                            ent_d[i].vi      = cdb_val(ent_q[i].qi);
                            ent_d[i].qi_busy = 1'b0;
                        end
                        if (ent_q[i].qj_busy && cdb_hit(ent_q[i].qj)) begin
                            ent_d[i].vj      = cdb_val(ent_q[i].qj);
                            ent_d[i].qj_busy = 1'b0;
                        end
                    end
                end

                // Dispatch: the selected entry's operands are already final,
                // so the registered copy is sent unchanged.
                if (ready_found) begin
                    busy_d[ready_idx] = 1'b0;
                    alu_op_d  = ent_q[ready_idx].op;
                    alu_vi_d  = ent_q[ready_idx].vi;
                    alu_vj_d  = ent_q[ready_idx].vj;
                    alu_imm_d = ent_q[ready_idx].imm;
                    alu_pc_d  = ent_q[ready_idx].pc;
                    alu_rd_d  = ent_q[ready_idx].rd;
                end else begin
                    alu_op_d  = OP_NOP;
                end

                // Issue: free slot comes from registered busy, so a slot being
                // vacated by dispatch this edge is not reused until next cycle.
                if (iss_valid && free_found) begin
                    busy_d[free_idx] = 1'b1;
                    ent_d[free_idx]  = new_ent;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q    <= '0;
            alu_op_q  <= OP_NOP;
            alu_vi_q  <= '0;
            alu_vj_q  <= '0;
            alu_imm_q <= '0;
            alu_pc_q  <= '0;
            alu_rd_q  <= '0;
        end else begin
            busy_q    <= busy_d;
            alu_op_q  <= alu_op_d;
            alu_vi_q  <= alu_vi_d;
            alu_vj_q  <= alu_vj_d;
            alu_imm_q <= alu_imm_d;
            alu_pc_q  <= alu_pc_d;
            alu_rd_q  <= alu_rd_d;
        end
    end

    // Entry payload is only meaningful while busy, so it carries no reset
    always_ff @(posedge clk_in) begin
        ent_q <= ent_d;
    end

    assign alu_op  = alu_op_q;
    assign alu_vi  = alu_vi_q;
    assign alu_vj  = alu_vj_q;
    assign alu_imm = alu_imm_q;
    assign alu_pc  = alu_pc_q;
    assign alu_rd  = alu_rd_q;

endmodule

// File: tb/tb_alu_rs.sv
// -----------------------------------------------------------------------------
// tb_alu_rs
//   Self-checking bench for alu_rs. Expected dispatches are queued when the
//   stimulus that should produce them is driven, and popped/compared by a
//   monitor whenever a new op appears on the ALU bus.
// -----------------------------------------------------------------------------
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int RS_SIZE = 8;
    localparam int TAG_W   = 5;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              flush_in;
    logic              iss_valid;
    logic [OP_W-1:0]   iss_op;
    logic [31:0]       iss_vi, iss_vj, iss_imm, iss_pc;
    logic              iss_qi_busy, iss_qj_busy;
    logic [TAG_W-1:0]  iss_qi, iss_qj, iss_rd;
    logic              full;
    logic              alu_cdb_valid, lsb_cdb_valid;
    logic [TAG_W-1:0]  alu_cdb_tag, lsb_cdb_tag;
    logic [31:0]       alu_cdb_val, lsb_cdb_val;
    logic [OP_W-1:0]   alu_op;
    logic [31:0]       alu_vi, alu_vj, alu_imm, alu_pc;
    logic [TAG_W-1:0]  alu_rd;

    alu_rs #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .iss_valid     (iss_valid),
        .iss_op        (iss_op),
        .iss_vi        (iss_vi),
        .iss_vj        (iss_vj),
        .iss_qi_busy   (iss_qi_busy),
        .iss_qj_busy   (iss_qj_busy),
        .iss_qi        (iss_qi),
        .iss_qj        (iss_qj),
        .iss_imm       (iss_imm),
        .iss_rd        (iss_rd),
        .iss_pc        (iss_pc),
        .full          (full),
        .alu_cdb_valid (alu_cdb_valid),
        .alu_cdb_tag   (alu_cdb_tag),
        .alu_cdb_val   (alu_cdb_val),
        .lsb_cdb_valid (lsb_cdb_valid),
        .lsb_cdb_tag   (lsb_cdb_tag),
        .lsb_cdb_val   (lsb_cdb_val),
        .alu_op        (alu_op),
        .alu_vi        (alu_vi),
        .alu_vj        (alu_vj),
        .alu_imm       (alu_imm),
        .alu_pc        (alu_pc),
        .alu_rd        (alu_rd)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [31:0]      vi;
        logic [31:0]      vj;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [TAG_W-1:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic rdy_edge = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // Monitor: a nonzero alu_op after an active (rdy_in=1) edge is a new dispatch
    always @(posedge clk_in) rdy_edge <= rdy_in;

    always @(negedge clk_in) begin
        if (rst_in && rdy_edge && alu_op != OP_NOP) begin
            if (sb.size() == 0) begin
                chk_eq("spurious_dispatch", 32'(alu_op), 32'(OP_NOP));
            end else begin
                mon_e = sb.pop_front();
                chk_eq("d_op",  32'(alu_op), 32'(mon_e.op));
                chk_eq("d_vi",  alu_vi,      mon_e.vi);
                chk_eq("d_vj",  alu_vj,      mon_e.vj);
                chk_eq("d_imm", alu_imm,     mon_e.imm);
                chk_eq("d_pc",  alu_pc,      mon_e.pc);
                chk_eq("d_rd",  32'(alu_rd), 32'(mon_e.rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        iss_valid     = 1'b0;
        flush_in      = 1'b0;
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
    endtask

    task automatic drive_iss(input logic [OP_W-1:0] op, input logic [31:0] vi, input logic [31:0] vj,
                             input logic qib, input logic [TAG_W-1:0] qi,
                             input logic qjb, input logic [TAG_W-1:0] qj,
                             input logic [31:0] imm, input logic [TAG_W-1:0] rd, input logic [31:0] pc);
        iss_valid   = 1'b1;
        iss_op      = op;
        iss_vi      = vi;
        iss_vj      = vj;
        iss_qi_busy = qib;
        iss_qi      = qi;
        iss_qj_busy = qjb;
        iss_qj      = qj;
        iss_imm     = imm;
        iss_rd      = rd;
        iss_pc      = pc;
    endtask

    task automatic push(input logic [OP_W-1:0] op, input logic [31:0] vi, input logic [31:0] vj,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [TAG_W-1:0] rd);
        exp_t e;
        e.op = op; e.vi = vi; e.vj = vj; e.imm = imm; e.pc = pc; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic alu_bcast(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        alu_cdb_valid = 1'b1;
        alu_cdb_tag   = tag;
        alu_cdb_val   = val;
    endtask

    task automatic lsb_bcast(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = tag;
        lsb_cdb_val   = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle();
        drive_iss(OP_NOP, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        iss_valid   = 1'b0;
        alu_cdb_tag = '0; alu_cdb_val = '0;
        lsb_cdb_tag = '0; lsb_cdb_val = '0;

        // Reset state
        @(negedge clk_in);
        chk_eq("rst_full",  32'(full),   32'd0);
        chk_eq("rst_op",    32'(alu_op), 32'(OP_NOP));
        chk_eq("rst_vi",    alu_vi,      32'd0);
        chk_eq("rst_vj",    alu_vj,      32'd0);
        chk_eq("rst_imm",   alu_imm,     32'd0);
        chk_eq("rst_pc",    alu_pc,      32'd0);
        chk_eq("rst_rd",    32'(alu_rd), 32'd0);
        tick();
        rst_in = 1'b1;
        tick();

        // A: ready ADD dispatches one edge after issue, then bus returns to NOP
        drive_iss(OP_ADD, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h11, 5'd3, 32'h1000);
        push(OP_ADD, 32'd5, 32'd7, 32'h11, 32'h1000, 5'd3);
        tick();
        idle();
        @(negedge clk_in);
        chk_eq("A_not_same_edge", 32'(alu_op), 32'(OP_NOP));
        tick();
        @(negedge clk_in);
        chk_eq("A_op", 32'(alu_op), 32'(OP_ADD));
        tick();
        @(negedge clk_in);
        chk_eq("A_freed_op", 32'(alu_op), 32'(OP_NOP));
        chk_eq("A_full", 32'(full), 32'd0);

        // B: SUB waits on tag 9, woken by the load bus
        tick();
        drive_iss(OP_SUB, 32'hX0, 32'd3, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd6, 32'h1004);
        push(OP_SUB, 32'h100, 32'd3, 32'h0, 32'h1004, 5'd6);
        tick();
        idle();
        tick();
        lsb_bcast(5'd9, 32'h100);
        tick();
        idle();
        @(negedge clk_in);
        chk_eq("B_not_same_edge", 32'(alu_op), 32'(OP_NOP));
        tick();
        @(negedge clk_in);
        chk_eq("B_op", 32'(alu_op), 32'(OP_SUB));

        // C: issue-time forwarding; ALU bus beats load bus on the same tag
        tick();
        drive_iss(OP_AND, 32'd1, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h22, 5'd7, 32'h1008);
        alu_bcast(5'd4, 32'hDEAD);
        lsb_bcast(5'd4, 32'hBEEF);
        push(OP_AND, 32'd1, 32'hDEAD, 32'h22, 32'h1008, 5'd7);
        tick();
        idle();
        @(negedge clk_in);
        chk_eq("C_not_same_edge", 32'(alu_op), 32'(OP_NOP));
        tick();
        @(negedge clk_in);
        chk_eq("C_op", 32'(alu_op), 32'(OP_AND));

        // D: fill all 8 slots; slots 2 and 5 wait on tag 10, the rest on 20
        tick();
        for (int i = 0; i < RS_SIZE; i++) begin
            drive_iss(OP_XORI, 32'(i), 32'(i + 100), 1'b1, (i == 2 || i == 5) ? 5'd10 : 5'd20,
                      1'b0, 5'd0, 32'(i + 200), 5'(i + 8), 32'h2000 + 32'(4 * i));
            tick();
        end
        idle();
        push(OP_XORI, 32'h55, 32'd102, 32'd202, 32'h2008, 5'd10);
        push(OP_XORI, 32'h55, 32'd105, 32'd205, 32'h2014, 5'd13);
        @(negedge clk_in);
        chk_eq("D_full", 32'(full), 32'd1);
        chk_eq("D_idle_op", 32'(alu_op), 32'(OP_NOP));
        tick();
        alu_bcast(5'd10, 32'h55);
        // Issue while full must be dropped; a ready op here would otherwise dispatch
        drive_iss(OP_ORI, 32'hBAD, 32'hBAD, 1'b0, 5'd0, 1'b0, 5'd0, 32'hBAD, 5'd30, 32'hBAD);
        tick();
        idle();
        @(negedge clk_in);
        chk_eq("D_still_full", 32'(full), 32'd1);
        tick();
        @(negedge clk_in);
        chk_eq("D_slot_freed", 32'(full), 32'd0);
        chk_eq("D_first_rd", 32'(alu_rd), 32'd10);
        tick();
        @(negedge clk_in);
        chk_eq("D_second_rd", 32'(alu_rd), 32'd13);
        tick();
        @(negedge clk_in);
        chk_eq("D_drained", 32'(alu_op), 32'(OP_NOP));

        // E: flush kills a pending-ready entry, the current dispatch and a same-cycle issue
        tick();
        drive_iss(OP_ADDI, 32'h77, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h3, 5'd1, 32'h3000);
        push(OP_ADDI, 32'h77, 32'h0, 32'h3, 32'h3000, 5'd1);
        tick();
        drive_iss(OP_SLTI, 32'h1, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h4, 5'd2, 32'h3004);
        tick();
        idle();
        @(negedge clk_in);
        chk_eq("E_pre_flush_op", 32'(alu_op), 32'(OP_ADDI));
        flush_in = 1'b1;
        drive_iss(OP_OR, 32'h9, 32'h9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 32'h3008);
        tick();
        idle();
        @(negedge clk_in);
        chk_eq("E_flush_op", 32'(alu_op), 32'(OP_NOP));
        chk_eq("E_flush_full", 32'(full), 32'd0);
        tick();
        alu_bcast(5'd20, 32'h123);
        tick();
        idle();
        tick();
        @(negedge clk_in);
        chk_eq("E_no_ghost", 32'(alu_op), 32'(OP_NOP));

        // F: rdy_in low blocks snooping and holds the output bus
        tick();
        drive_iss(OP_SLT, 32'h0, 32'h5, 1'b1, 5'd22, 1'b0, 5'd0, 32'h6, 5'd5, 32'h4000);
        tick();
        idle();
        rdy_in = 1'b0;
        alu_bcast(5'd22, 32'h99);
        tick();
        tick();
        idle();
        rdy_in = 1'b1;
        tick();
        tick();
        @(negedge clk_in);
        chk_eq("F_no_wake", 32'(alu_op), 32'(OP_NOP));
        lsb_bcast(5'd22, 32'hAB);
        push(OP_SLT, 32'hAB, 32'h5, 32'h6, 32'h4000, 5'd5);
        tick();
        idle();
        tick();
        @(negedge clk_in);
        chk_eq("F_wake_op", 32'(alu_op), 32'(OP_SLT));
        rdy_in = 1'b0;
        tick();
        @(negedge clk_in);
        chk_eq("F_hold_op", 32'(alu_op), 32'(OP_SLT));
        chk_eq("F_hold_vi", alu_vi, 32'hAB);
        rdy_in = 1'b1;
        tick();
        @(negedge clk_in);
        chk_eq("F_resume_op", 32'(alu_op), 32'(OP_NOP));

        // G: async reset mid-run with three pending entries and a live dispatch
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_iss(OP_BEQ, 32'h0, 32'h0, 1'b1, 5'd21, 1'b0, 5'd0, 32'h0, 5'(16 + i), 32'h5000);
            tick();
        end
        drive_iss(OP_ADD, 32'h31, 32'h32, 1'b0, 5'd0, 1'b0, 5'd0, 32'h33, 5'd9, 32'h5010);
        push(OP_ADD, 32'h31, 32'h32, 32'h33, 32'h5010, 5'd9);
        tick();
        idle();
        tick();
        @(negedge clk_in);
        chk_eq("G_pre_rst_op", 32'(alu_op), 32'(OP_ADD));
        #2;
        rst_in = 1'b0;
        #1;
        chk_eq("G_rst_op",   32'(alu_op), 32'(OP_NOP));
        chk_eq("G_rst_full", 32'(full),   32'd0);
        chk_eq("G_rst_vi",   alu_vi,      32'd0);
        chk_eq("G_rst_rd",   32'(alu_rd), 32'd0);
        tick();
        rst_in = 1'b1;
        alu_bcast(5'd21, 32'h77);
        tick();
        idle();
        tick();
        tick();
        @(negedge clk_in);
        chk_eq("G_no_dispatch", 32'(alu_op), 32'(OP_NOP));
        drive_iss(OP_BNE, 32'h41, 32'h42, 1'b0, 5'd0, 1'b0, 5'd0, 32'h43, 5'd11, 32'h6000);
        push(OP_BNE, 32'h41, 32'h42, 32'h43, 32'h6000, 5'd11);
        tick();
        idle();
        tick();
        @(negedge clk_in);
        chk_eq("G_after_issue", 32'(alu_op), 32'(OP_BNE));
        tick();

        chk_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
